// File: rtl/tft_spi_tx.sv
// tft_spi_tx: byte-wide SPI (mode 0, MSB first) transmitter for the TFT panel.
// Also sequences the panel hardware reset after system reset. Every output
// is a register; the combinational process computes the next value of each.
module tft_spi_tx #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_GAP   = 2,
  parameter int unsigned RST_LOW  = 500,
  parameter int unsigned RST_WAIT = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       transmit,
  input  logic       dc,
  input  logic [7:0] data,
  output logic       busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc,
  output logic       lcd_rst_n
);

  localparam int unsigned RMAX = (RST_LOW > RST_WAIT) ? RST_LOW : RST_WAIT;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam int unsigned DMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned DW   = $clog2(DMAX + 1);

  typedef enum logic [2:0] {
    RST_LO,
    RST_HI,
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_t;

  state_t        state, state_nx;
  logic [RW-1:0] rst_cnt, rst_cnt_nx;
  logic [DW-1:0] div_cnt, div_cnt_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          busy_nx, sclk_nx, mosi_nx, cs_n_nx, dc_nx, lcd_rst_n_nx;

  // State, counters and registered outputs; synchronous reset restarts the panel reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_LO;
      rst_cnt   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      busy      <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_dc    <= 1'b0;
      lcd_rst_n <= 1'b0;
    end else begin
      state     <= state_nx;
      rst_cnt   <= rst_cnt_nx;
      div_cnt   <= div_cnt_nx;
      bit_cnt   <= bit_cnt_nx;
      shreg     <= shreg_nx;
      busy      <= busy_nx;
      spi_sclk  <= sclk_nx;
      spi_mosi  <= mosi_nx;
      spi_cs_n  <= cs_n_nx;
      spi_dc    <= dc_nx;
      lcd_rst_n <= lcd_rst_n_nx;
    end
  end

  // Next-state and next-output logic. In SHIFT the sclk register itself
  // marks the half-period: high phase ends with a falling edge and the next
  // bit on mosi; low phase ends with a rising edge or, after bit 7, with cs release.
  always_comb begin
    state_nx     = state;
    rst_cnt_nx   = rst_cnt;
    div_cnt_nx   = div_cnt;
    bit_cnt_nx   = bit_cnt;
    shreg_nx     = shreg;
    busy_nx      = busy;
    sclk_nx      = spi_sclk;
    mosi_nx      = spi_mosi;
    cs_n_nx      = spi_cs_n;
    dc_nx        = spi_dc;
    lcd_rst_n_nx = lcd_rst_n;

    unique case (state)
      RST_LO: begin
        if (rst_cnt == RW'(RST_LOW - 1)) begin
          state_nx     = RST_HI;
          rst_cnt_nx   = '0;
          lcd_rst_n_nx = 1'b1;
        end else begin
          rst_cnt_nx = rst_cnt + RW'(1);
        end
      end

      RST_HI: begin
        if (rst_cnt == RW'(RST_WAIT - 1)) begin
          state_nx   = IDLE;
          rst_cnt_nx = '0;
          busy_nx    = 1'b0;
        end else begin
          rst_cnt_nx = rst_cnt + RW'(1);
        end
      end

      IDLE: begin
        if (transmit) begin
          state_nx   = SETUP;
          shreg_nx   = data;
          dc_nx      = dc;
          mosi_nx    = data[7];
          cs_n_nx    = 1'b0;
          busy_nx    = 1'b1;
          div_cnt_nx = '0;
        end
      end

      SETUP: begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          state_nx   = SHIFT;
          div_cnt_nx = '0;
          bit_cnt_nx = '0;
          sclk_nx    = 1'b1;
        end else begin
          div_cnt_nx = div_cnt + DW'(1);
        end
      end

      SHIFT: begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_cnt_nx = '0;
          if (spi_sclk) begin
            sclk_nx  = 1'b0;
            shreg_nx = {shreg[6:0], 1'b0};
            mosi_nx  = shreg[6];
          end else if (bit_cnt == 3'd7) begin
            state_nx = GAP;
            cs_n_nx  = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
            sclk_nx    = 1'b1;
          end
        end else begin
          div_cnt_nx = div_cnt + DW'(1);
        end
      end

      GAP: begin
        if (div_cnt == DW'(CS_GAP - 1)) begin
          state_nx   = IDLE;
          div_cnt_nx = '0;
          busy_nx    = 1'b0;
        end else begin
          div_cnt_nx = div_cnt + DW'(1);
        end
      end

      default: begin
        state_nx = RST_LO;
      end
    endcase
  end

endmodule

// File: tb/tb_tft_spi_tx.sv
// tb_tft_spi_tx: directed bench for tft_spi_tx. One instance with CLK_DIV=2
// and one with CLK_DIV=1 share clock and reset; sel picks which is driven/observed.
module tb_tft_spi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_req;
  logic       dc;
  logic [7:0] data;
  logic       sel;

  logic transmit0, busy0, sclk0, mosi0, cs_n0, dc0, lcd0;
  logic transmit1, busy1, sclk1, mosi1, cs_n1, dc1, lcd1;
  logic o_busy, o_sclk, o_mosi, o_cs_n, o_dc, o_lcd;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] rx;
    int         nbits;
    int         busy;
    int         cs_low;
    int         dc_bad;
    int         mosi_bad;
    int         windows;
    int         gap;
    int         per_bad;
    int         first_rise;
    int         sclk_bad;
  } res_t;

  always #5 clk = ~clk;

  assign transmit0 = tx_req & ~sel;
  assign transmit1 = tx_req & sel;

  tft_spi_tx #(.CLK_DIV(2), .CS_GAP(2), .RST_LOW(4), .RST_WAIT(8)) u_dut0 (
    .clk(clk), .rst(rst), .transmit(transmit0), .dc(dc), .data(data),
    .busy(busy0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_cs_n(cs_n0),
    .spi_dc(dc0), .lcd_rst_n(lcd0)
  );

  tft_spi_tx #(.CLK_DIV(1), .CS_GAP(2), .RST_LOW(4), .RST_WAIT(8)) u_dut1 (
    .clk(clk), .rst(rst), .transmit(transmit1), .dc(dc), .data(data),
    .busy(busy1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_cs_n(cs_n1),
    .spi_dc(dc1), .lcd_rst_n(lcd1)
  );

  // Route the selected instance's outputs to the observation signals.
  always_comb begin
    o_busy = sel ? busy1 : busy0;
    o_sclk = sel ? sclk1 : sclk0;
    o_mosi = sel ? mosi1 : mosi0;
    o_cs_n = sel ? cs_n1 : cs_n0;
    o_dc   = sel ? dc1   : dc0;
    o_lcd  = sel ? lcd1  : lcd0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Pulse transmit, then follow the byte until busy drops (left at the first
  // busy-low cycle). Optionally inject a request during bit inj_bit, or stop
  // early once bit abort_bit is being clocked.
  task automatic send_byte(input logic d_c, input logic [7:0] b, input int div,
                           input int inj_bit, input int abort_bit, output res_t r);
    logic prev_sclk, prev_mosi, prev_cs;
    int   last_rise;
    bit   injected;
    r = '{rx: 8'h00, nbits: 0, busy: 0, cs_low: 0, dc_bad: 0, mosi_bad: 0,
          windows: 0, gap: 0, per_bad: 0, first_rise: -1, sclk_bad: 0};
    prev_sclk = o_sclk;
    prev_mosi = o_mosi;
    prev_cs   = o_cs_n;
    last_rise = -1;
    injected  = 1'b0;
    tx_req = 1'b1; dc = d_c; data = b;
    tick();
    tx_req = 1'b0; dc = ~d_c; data = ~b;
    for (int c = 0; c < 200; c++) begin
      if (!o_busy) break;
      r.busy++;
      if (!o_cs_n) begin
        r.cs_low++;
        if (o_dc != d_c) r.dc_bad++;
      end else begin
        if (r.windows > 0) r.gap++;
        if (o_sclk) r.sclk_bad++;
      end
      if (prev_cs && !o_cs_n) r.windows++;
      if (c > 0 && o_mosi != prev_mosi && !(prev_sclk && !o_sclk)) r.mosi_bad++;
      if (o_sclk && !prev_sclk) begin
        r.rx = {r.rx[6:0], o_mosi};
        r.nbits++;
        if (last_rise < 0) r.first_rise = c;
        else if (c - last_rise != 2 * div) r.per_bad++;
        last_rise = c;
      end
      prev_sclk = o_sclk;
      prev_mosi = o_mosi;
      prev_cs   = o_cs_n;
      if (abort_bit >= 0 && r.nbits == abort_bit + 1 && o_sclk) break;
      if (inj_bit >= 0 && !injected && r.nbits == inj_bit + 1 && o_sclk) begin
        tx_req = 1'b1; data = 8'hFF; dc = ~d_c; injected = 1'b1;
      end else begin
        tx_req = 1'b0;
      end
      tick();
    end
    tx_req = 1'b0;
  endtask

  task automatic check_byte(input string p, input res_t r, input logic [7:0] exp_rx,
                            input int exp_busy, input int exp_cs, input int exp_first);
    check({p, "_rx"},         int'(r.rx), int'(exp_rx));
    check({p, "_nbits"},      r.nbits, 8);
    check({p, "_busy"},       r.busy, exp_busy);
    check({p, "_cs_low"},     r.cs_low, exp_cs);
    check({p, "_windows"},    r.windows, 1);
    check({p, "_gap"},        r.gap, 2);
    check({p, "_dc"},         r.dc_bad, 0);
    check({p, "_mosi_stable"}, r.mosi_bad, 0);
    check({p, "_period"},     r.per_bad, 0);
    check({p, "_first_rise"}, r.first_rise, exp_first);
    check({p, "_sclk_idle"},  r.sclk_bad, 0);
  endtask

  // Expects rst to have been high over the last edge; checks the reset values,
  // releases rst and measures the panel reset sequence.
  task automatic reset_seq(input string p);
    int nbusy, nlcd_low, bad;
    check({p, "_rst_cs_n"}, int'(o_cs_n), 1);
    check({p, "_rst_sclk"}, int'(o_sclk), 0);
    check({p, "_rst_mosi"}, int'(o_mosi), 0);
    check({p, "_rst_dc"},   int'(o_dc), 0);
    check({p, "_rst_lcd"},  int'(o_lcd), 0);
    check({p, "_rst_busy"}, int'(o_busy), 1);
    rst = 1'b0;
    nbusy = 0; nlcd_low = 0; bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (!o_busy) break;
      nbusy++;
      if (!o_lcd) begin
        nlcd_low++;
        if (nbusy != nlcd_low) bad++;
      end
      if (!o_cs_n || o_sclk) bad++;
      tick();
    end
    check({p, "_busy_len"}, nbusy, 12);
    check({p, "_lcd_low"},  nlcd_low, 4);
    check({p, "_quiet"},    bad, 0);
    check({p, "_lcd_high"}, int'(o_lcd), 1);
  endtask

  initial begin
    res_t r, r2;
    sel = 1'b0; rst = 1'b1; tx_req = 1'b1; dc = 1'b1; data = 8'hC3;
    // transmit is held high during reset and must not be accepted
    tick(); tick(); tick();
    tx_req = 1'b0;
    reset_seq("init");

    // command byte 0x2A
    send_byte(1'b0, 8'h2A, 2, -1, -1, r);
    check_byte("cmd", r, 8'h2A, 36, 34, 2);

    // back-to-back: second request on the first busy-low cycle
    send_byte(1'b1, 8'h01, 2, -1, -1, r);
    send_byte(1'b1, 8'h3F, 2, -1, -1, r2);
    check_byte("b2b0", r, 8'h01, 36, 34, 2);
    check_byte("b2b1", r2, 8'h3F, 36, 34, 2);
    check("b2b_dc_after", int'(o_dc), 1);

    // ignored request during bit 2 of 0x00
    send_byte(1'b0, 8'h00, 2, 2, -1, r);
    check_byte("ign", r, 8'h00, 36, 34, 2);
    tick();
    check("ign_no_queue", int'(o_busy), 0);
    check("ign_cs_idle", int'(o_cs_n), 1);

    // reset while bit 4 of 0xA5 is being clocked
    send_byte(1'b1, 8'hA5, 2, -1, 4, r);
    check("mid_nbits", r.nbits, 5);
    check("mid_partial", int'(r.rx[4:0]), 5'b10100);
    check("mid_sclk_hi", int'(o_sclk), 1);
    rst = 1'b1;
    tick();
    reset_seq("mid");
    send_byte(1'b1, 8'h5A, 2, -1, -1, r);
    check_byte("after_mid", r, 8'h5A, 36, 34, 2);

    // CLK_DIV=1 instance
    sel = 1'b1;
    tick();
    check("div1_idle_busy", int'(o_busy), 0);
    send_byte(1'b1, 8'h80, 1, -1, -1, r);
    check_byte("div1", r, 8'h80, 19, 17, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tft_spi_tx.md
# tft_spi_tx

Byte-level SPI transmitter for the TFT panel. It sits between the panel command/data sequencers and the panel pins. It accepts one byte plus D/C flag per `transmit` pulse and shifts it out MSB-first in SPI mode 0. It signals `busy` until the byte and inter-byte chip-select gap complete. It also generates the panel hardware-reset pulse after system reset and holds `busy` until the panel is ready.

## Interface
Parameters:
- `CLK_DIV`, 2: sclk half-period in clk cycles; legal range ≥1.
- `CS_GAP`, 2: clk cycles `spi_cs_n` stays high after each byte before IDLE; legal range ≥1.
- `RST_LOW`, 500: clk cycles `lcd_rst_n` is held low after reset; legal range ≥1.
- `RST_WAIT`, 6000000: clk cycles after `lcd_rst_n` rises before the first byte is accepted; legal range ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `transmit` in 1: one-cycle request; sampled only when `busy`=0.
- `dc` in 1: D/C flag for the byte (0 = command, 1 = data).
- `data` in 8: byte to send.
- `busy` out 1: high while resetting the panel or sending.
- `spi_sclk` out 1: serial clock, idle low.
- `spi_mosi` out 1: serial data.
- `spi_cs_n` out 1: chip select, active low.
- `spi_dc` out 1: panel D/C line.
- `lcd_rst_n` out 1: panel hardware reset, active low.

## Operation
- All outputs are registered.
- Values while `rst`=1: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `spi_dc`=0, `lcd_rst_n`=0, `busy`=1, state=RST_LO, counters=0.
- **RST_LO**: `lcd_rst_n`=0 for `RST_LOW` cycles, then go to RST_HI.
- **RST_HI**: `lcd_rst_n`=1 for `RST_WAIT` cycles, then go to IDLE.
- **IDLE**:
  - `busy`=0, `spi_cs_n`=1, `spi_sclk`=0.
  - On `transmit`=1, latch `data` and `dc` into shift/flag registers and go to SETUP.
  - `busy` rises on the same clock edge that latches the byte.
- **SETUP**: `spi_cs_n`=0, `spi_dc`=latched dc, `spi_mosi`=bit7, `spi_sclk`=0, for `CLK_DIV` cycles.
- **SHIFT**: 8 bits, each `CLK_DIV` cycles sclk high then `CLK_DIV` cycles sclk low.
  - mosi changes only on the sclk falling transition, to the next bit.
  - mosi is stable across every rising edge.
  - After the 8th low phase, `spi_cs_n` goes to 1 and the state goes to GAP.
- **GAP**: `spi_cs_n`=1 for `CS_GAP` cycles, then go to IDLE.
- `spi_dc` keeps its value after the byte until the next latch.
- `transmit` while `busy`=1 is ignored entirely: no latch, no queueing. `data`/`dc` are don't-care when `transmit`=0.
- Counters are sized with $clog2 of their parameter and must not wrap within a phase. The bit counter runs 0..7.

## Timing
- Busy per byte = `CLK_DIV`·17 + `CS_GAP` cycles after the accept edge. With the defaults this is 36.
- A request is accepted in the first cycle `busy`=0. Back-to-back bytes have exactly `CS_GAP` cycles of `spi_cs_n` high between them.
- After `rst` deasserts, `busy`=1 for `RST_LOW`+`RST_WAIT` cycles. `lcd_rst_n` rises after exactly `RST_LOW` cycles.
- Reset mid-byte or mid-reset-sequence:
  - The next clock edge forces the reset values: cs high, sclk low, `lcd_rst_n` low.
  - The partial byte is discarded and the panel reset sequence restarts.
- `transmit` in the same cycle as `rst`=1 is ignored.

## Test plan
Parameters for all scenarios unless stated: CLK_DIV=2, CS_GAP=2, RST_LOW=4, RST_WAIT=8.
- **Reset release.** Deassert rst → `lcd_rst_n` low 4 cycles then high. `busy`=1 for 12 cycles then 0. `spi_cs_n`=1 and `spi_sclk`=0 throughout.
- **Command byte.** Pulse transmit with dc=0, data=0x2A.
  - Required: 8 sclk rising edges with mosi sampled 0,0,1,0,1,0,1,0.
  - `spi_dc`=0 while cs is low. cs low for 34 cycles. `busy` high for 36 cycles.
- **Back-to-back.** Send 0x01 (dc=1), then pulse 0x3F (dc=1) on the first busy-low cycle.
  - Required: `spi_cs_n` high for exactly 2 cycles between the bytes.
  - Second byte sampled as 0,0,1,1,1,1,1,1. `spi_dc`=1 for both bytes.
- **Ignored request.** Pulse transmit with 0xFF during the 3rd bit of byte 0x00 → only 0x00 is shifted. Exactly one cs-low window. `busy` timing unchanged.
- **Mid-byte reset.** Assert rst during bit 4 of 0xA5.
  - Next edge: cs_n=1, sclk=0, `lcd_rst_n`=0, `busy`=1.
  - After release, the full 4+8 reset sequence repeats and no residual sclk edges appear.
- **CLK_DIV=1.** Send 0x80 → sclk period of 2 cycles, mosi sampled 1 then seven 0s, `busy` high for 19 cycles.
